// File: rtl/sub_state_seq_pkg.sv
// Shared types and S-box arithmetic for the byte-serial SubBytes sequencer.
//   seq_state_t     : sequencer FSM encoding (IDLE, RUN, DONE)
//   BYTES_PER_STATE : bytes in one AES state
//   sbox_fwd/inv    : S-box values computed from GF(2^8) arithmetic
package aes_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam int BYTES_PER_STATE = 16;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/sub_state_seq_if.sv
// Request/response bundle between the round controller and the sequencer.
//   start, inv, state_in : request (driven by master)
//   busy, done, state_out: status and result (driven by slave)
interface sub_state_seq_if;
    logic         start;
    logic         inv;
    logic [127:0] state_in;
    logic         busy;
    logic         done;
    logic [127:0] state_out;

    modport master (output start, inv, state_in, input busy, done, state_out);
    modport slave  (input start, inv, state_in, output busy, done, state_out);
endinterface

// File: rtl/sub_state_seq_lane.sv
// One substitution lane: forward and inverse S-box on the same byte,
// selected by mode and registered on the falling clock edge.
//   clk  : system clock (lane register uses the falling edge)
//   mode : 0 = SubBytes, 1 = InvSubBytes (latched mode from the sequencer)
//   din  : input byte
//   dout : substituted byte, valid from the falling edge onward
import aes_seq_pkg::*;

module sbox_lane (
    input  logic       clk,
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [7:0] fwd_b;
    logic [7:0] inv_b;

    assign fwd_b = sbox_fwd(din);
    assign inv_b = sbox_inv(din);

    always_ff @(negedge clk) begin
        dout <= mode ? inv_b : fwd_b;
    end
endmodule

// File: rtl/sub_state_seq.sv
// Byte-serial SubBytes/InvSubBytes over a 128-bit state using LANES shared
// lookup lanes, processed MSB chunk first.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of sub_state_seq_if (start/inv/state_in in,
//           busy/done/state_out out)
// LANES must divide 16 (1, 2, 4, 8 or 16).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | substituting chunk idx; result chunk written each rising edge
// DONE  | one-cycle done pulse; start here is accepted back-to-back
import aes_seq_pkg::*;

module sub_state_seq #(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          reset,
    sub_state_seq_if.slave bus
);
    localparam int NCHUNK = BYTES_PER_STATE / LANES;
    localparam int CHUNKW = LANES * 8;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              accept;
    logic              busy;
    logic              done;
    logic [IDXW-1:0]   idx;
    logic              mode;
    logic [127:0]      work;
    logic [127:0]      result;
    logic [127:0]      result_next;
    logic [127:0]      state_out_q;
    logic [6:0]        chunk_hi;
    logic [CHUNKW-1:0] chunk_in;
    logic [CHUNKW-1:0] chunk_out;

    // idx is registered, so lane addresses settle well before the falling edge.
    assign chunk_hi = 7'(127 - CHUNKW * int'(idx));
    assign chunk_in = work[chunk_hi -: CHUNKW];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_lane u_lane (
            .clk  (clk),
            .mode (mode),
            .din  (chunk_in[CHUNKW-1-8*j -: 8]),
            .dout (chunk_out[CHUNKW-1-8*j -: 8])
        );
    end

    always_comb begin
        result_next = result;
        result_next[chunk_hi -: CHUNKW] = chunk_out;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            mode        <= 1'b0;
            work        <= '0;
            result      <= '0;
            state_out_q <= '0;
        end else if (accept) begin
            work <= bus.state_in;
            mode <= bus.inv;
            idx  <= '0;
        end else if (state == RUN) begin
            result <= result_next;
            if (idx == LAST_IDX) begin
                idx         <= '0;
                // result_next already holds the final chunk, so the
                // published state is never partial.
                state_out_q <= result_next;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.state_out = state_out_q;
endmodule

// File: tb/tb_sub_state_seq.sv
module tb_sub_state_seq;
    localparam logic [127:0] VEC_A  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_B  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_63 = {16{8'h63}};
    localparam logic [127:0] ALL_FF = {16{8'hff}};
    localparam logic [127:0] ALL_16 = {16{8'h16}};
    localparam logic [127:0] JUNK   = 128'h0123456789abcdeffedcba9876543210;

    typedef struct {
        logic [127:0] st;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_state_seq_if m ();
    sub_state_seq_if w1 ();
    sub_state_seq_if w2 ();
    sub_state_seq_if w16 ();

    sub_state_seq #(.LANES(4))  dut    (.clk(clk), .reset(reset), .bus(m));
    sub_state_seq #(.LANES(1))  dut_1  (.clk(clk), .reset(reset), .bus(w1));
    sub_state_seq #(.LANES(2))  dut_2  (.clk(clk), .reset(reset), .bus(w2));
    sub_state_seq #(.LANES(16)) dut_16 (.clk(clk), .reset(reset), .bus(w16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request; inputs are scrambled right after acceptance to show
    // that only the latched copies matter.
    task automatic start_job(input logic iv, input logic [127:0] st,
                             input logic [127:0] ex, input bit push);
        m.start    = 1'b1;
        m.inv      = iv;
        m.state_in = st;
        tick();
        m.start    = 1'b0;
        m.inv      = ~iv;
        m.state_in = ~st;
        if (push) sbq.push_back('{ex, 4, cyc});
    endtask

    task automatic wait_done(input string tag);
        int   n;
        bit   busy_ok;
        exp_t e;
        n = 0;
        busy_ok = 1'b1;
        while (m.done !== 1'b1 && n < 64) begin
            if (m.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_sb_nonempty"}, 128'(sbq.size() > 0), 128'(1));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_latency"}, 128'(cyc - e.acc), 128'(e.lat));
            chk({tag, "_state_out"}, m.state_out, e.st);
            chk({tag, "_busy_in_run"}, 128'(busy_ok), 128'(1));
            chk({tag, "_busy_at_done"}, 128'(m.busy), 128'(0));
        end
    endtask

    task automatic after_done(input string tag, input logic [127:0] held);
        tick();
        chk({tag, "_done_one_cycle"}, 128'(m.done), 128'(0));
        chk({tag, "_out_held"}, m.state_out, held);
    endtask

    initial begin
        bit seen_done;
        bit s1, s2, s16;
        int l1, l2, l16, acc;
        logic [127:0] o1, o2, o16;

        m.start = 1'b0;   m.inv = 1'b0;   m.state_in = '0;
        w1.start = 1'b0;  w1.inv = 1'b0;  w1.state_in = '0;
        w2.start = 1'b0;  w2.inv = 1'b0;  w2.state_in = '0;
        w16.start = 1'b0; w16.inv = 1'b0; w16.state_in = '0;

        // Reset with start held: reset must win.
        m.start = 1'b1;
        tick();
        tick();
        m.start = 1'b0;
        chk("rst_busy", 128'(m.busy), 128'(0));
        chk("rst_done", 128'(m.done), 128'(0));
        chk("rst_state_out", m.state_out, 128'h0);
        reset = 1'b0;
        tick();
        chk("rst_idle_busy", 128'(m.busy), 128'(0));

        start_job(1'b0, VEC_A, VEC_B, 1'b1);
        wait_done("fwd");
        after_done("fwd", VEC_B);

        start_job(1'b1, VEC_B, VEC_A, 1'b1);
        wait_done("inv");
        after_done("inv", VEC_A);

        start_job(1'b0, 128'h0, ALL_63, 1'b1);
        wait_done("zero_fwd");
        after_done("zero_fwd", ALL_63);

        start_job(1'b1, ALL_63, 128'h0, 1'b1);
        wait_done("x63_inv");
        after_done("x63_inv", 128'h0);

        start_job(1'b0, ALL_FF, ALL_16, 1'b1);
        wait_done("ff_fwd");
        after_done("ff_fwd", ALL_16);

        // Back-to-back: junk start during RUN ignored, start in DONE accepted.
        start_job(1'b0, VEC_A, VEC_B, 1'b1);
        tick();
        m.start = 1'b1;
        m.inv = 1'b1;
        m.state_in = JUNK;
        tick();
        m.start = 1'b0;
        wait_done("b2b_fwd");
        start_job(1'b1, VEC_B, VEC_A, 1'b1);
        wait_done("b2b_inv");
        after_done("b2b_inv", VEC_A);

        // Reset in the second RUN cycle aborts the job.
        start_job(1'b0, VEC_A, VEC_B, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 128'(m.busy), 128'(0));
        chk("abort_done", 128'(m.done), 128'(0));
        chk("abort_state_out", m.state_out, 128'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m.done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 128'(seen_done), 128'(0));
        chk("abort_out_zero", m.state_out, 128'h0);

        start_job(1'b0, VEC_A, VEC_B, 1'b1);
        wait_done("post_abort");
        after_done("post_abort", VEC_B);

        chk("sb_drained", 128'(sbq.size()), 128'(0));

        // Parameter sweep: same forward case on LANES=1, 2, 16.
        w1.start = 1'b1;  w1.inv = 1'b0;  w1.state_in = VEC_A;
        w2.start = 1'b1;  w2.inv = 1'b0;  w2.state_in = VEC_A;
        w16.start = 1'b1; w16.inv = 1'b0; w16.state_in = VEC_A;
        tick();
        acc = cyc;
        w1.start = 1'b0;  w1.state_in = JUNK;
        w2.start = 1'b0;  w2.state_in = JUNK;
        w16.start = 1'b0; w16.state_in = JUNK;
        s1 = 1'b0; s2 = 1'b0; s16 = 1'b0;
        l1 = -1; l2 = -1; l16 = -1;
        o1 = '0; o2 = '0; o16 = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (w1.done === 1'b1 && !s1)   begin s1 = 1'b1;  l1 = cyc - acc;  o1 = w1.state_out;  end
            if (w2.done === 1'b1 && !s2)   begin s2 = 1'b1;  l2 = cyc - acc;  o2 = w2.state_out;  end
            if (w16.done === 1'b1 && !s16) begin s16 = 1'b1; l16 = cyc - acc; o16 = w16.state_out; end
        end
        chk("lanes1_latency", 128'(l1), 128'(16));
        chk("lanes2_latency", 128'(l2), 128'(8));
        chk("lanes16_latency", 128'(l16), 128'(1));
        chk("lanes1_state_out", o1, VEC_B);
        chk("lanes2_state_out", o2, VEC_B);
        chk("lanes16_state_out", o16, VEC_B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
